// File: rtl/score_bcd_converter.sv
// score_bcd_converter: sequential binary-to-BCD converter using shift-and-add-3,
// one input bit per clock. The packed BCD digits and the leading-zero blanking
// mask are published together with a one-cycle o_valid pulse, so a reader
// never observes a partially converted value.
module score_bcd_converter #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic [BIN_W-1:0]      i_bin,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic [DIGITS-1:0]     o_digit_en,
   output logic                  o_valid,
   output logic                  o_busy
);

   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t                state;
   logic [BIN_W-1:0]      bin_sr;
   logic [4*DIGITS-1:0]   bcd_sr;
   logic [4*DIGITS-1:0]   bcd_adj;
   logic [CNT_W-1:0]      cnt;
   logic [DIGITS-1:0]     digit_mask;

   // Add-3 adjust: every digit >= 5 gets +3, independently (no inter-digit carry).
   always_comb begin
      bcd_adj = bcd_sr;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (bcd_sr[4*d +: 4] >= 4'd5) begin
            bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
         end
      end
   end

   // Leading-zero mask: a digit is shown if it or any more significant digit is nonzero;
   // the ones digit is always shown.
   always_comb begin
      logic any_nz;
      any_nz     = 1'b0;
      digit_mask = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         any_nz = any_nz | (|bcd_sr[4*(DIGITS-1-i) +: 4]);
         digit_mask[DIGITS-1-i] = any_nz;
      end
      digit_mask[0] = 1'b1;
   end

   // Control FSM, scratch shift registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bin_sr     <= '0;
         bcd_sr     <= '0;
         cnt        <= '0;
         o_bcd      <= '0;
         o_digit_en <= DIGITS'(1);
         o_valid    <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  bin_sr <= i_bin;
                  bcd_sr <= '0;
                  cnt    <= '0;
                  o_busy <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               // Shift the adjusted digits and the binary MSB in as one wide register.
               bcd_sr <= {bcd_adj[4*DIGITS-2:0], bin_sr[BIN_W-1]};
               bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_CNT) begin
                  state <= DONE;
               end
            end
            DONE: begin
               o_bcd      <= bcd_sr;
               o_digit_en <= digit_mask;
               o_valid    <= 1'b1;
               o_busy     <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_score_bcd_converter.sv
// tb_score_bcd_converter: directed and randomised checks of score_bcd_converter
// against a decimal-text reference model (%05d formatting) and plain arithmetic.
module tb_score_bcd_converter;

   logic        clk;
   logic        rst_n;
   logic        i_start;
   logic [15:0] i_bin;
   logic [19:0] o_bcd;
   logic [4:0]  o_digit_en;
   logic        o_valid;
   logic        o_busy;

   int total = 0;
   int bad   = 0;
   logic [19:0] last_bcd;
   logic [4:0]  last_en;

   score_bcd_converter #(.BIN_W(16), .DIGITS(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (i_start),
      .i_bin      (i_bin),
      .o_bcd      (o_bcd),
      .o_digit_en (o_digit_en),
      .o_valid    (o_valid),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: decimal text of the value, each character becomes one BCD nibble.
   function automatic logic [19:0] ref_bcd(input int v);
      string s;
      logic [19:0] r;
      $sformat(s, "%05d", v);
      r = '0;
      for (int i = 0; i < 5; i++) begin
         r = {r[15:0], 4'(s[i] - 8'd48)};
      end
      return r;
   endfunction

   // Reference: digit k shown when the value reaches 10**k (ones digit always).
   function automatic logic [4:0] ref_mask(input int v);
      logic [4:0] m;
      int p;
      m = '0;
      p = 1;
      for (int k = 0; k < 5; k++) begin
         if (k == 0 || v >= p) m[k] = 1'b1;
         p = p * 10;
      end
      return m;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Single start pulse; checks latency, holding of old outputs, result and idle afterwards.
   task automatic convert(input int v);
      int n;
      logic seen;
      @(negedge clk);
      i_bin   = 16'(v);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_bin   = 16'($urandom_range(0, 65535));
      check("busy_after_start", 32'(o_busy), 32'd1);
      n    = 0;
      seen = 1'b0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk);
         if (o_valid) begin
            seen = 1'b1;
            n    = i;
         end else begin
            check("hold_bcd", 32'(o_bcd), 32'(last_bcd));
            check("hold_en", 32'(o_digit_en), 32'(last_en));
            i_bin = 16'($urandom_range(0, 65535));
         end
      end
      check("latency", 32'(n), 32'd17);
      check("result_bcd", 32'(o_bcd), 32'(ref_bcd(v)));
      check("result_en", 32'(o_digit_en), 32'(ref_mask(v)));
      check("busy_at_valid", 32'(o_busy), 32'd0);
      last_bcd = ref_bcd(v);
      last_en  = ref_mask(v);
      @(negedge clk);
      check("valid_one_cycle", 32'(o_valid), 32'd0);
      check("idle_not_busy", 32'(o_busy), 32'd0);
   endtask

   int vals[$];
   int idx;
   int gap;
   int nvalid;

   initial begin
      rst_n   = 1'b1;
      i_start = 1'b0;
      i_bin   = '0;
      last_bcd = '0;
      last_en  = 5'b00001;

      // 1: asynchronous reset, checked before any clock edge
      #2 rst_n = 1'b0;
      #1;
      check("rst_bcd", 32'(o_bcd), 32'h0);
      check("rst_en", 32'(o_digit_en), 32'b00001);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 2, 3: directed values
      convert(0);
      convert(1234);
      convert(65535);
      convert(10000);
      convert(9);
      convert(100);

      // 4: start during busy is ignored, i_bin changes have no effect
      @(negedge clk);
      i_bin   = 16'd42;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_bin   = 16'd5;
      repeat (4) @(negedge clk);
      i_start = 1'b1;
      i_bin   = 16'd999;
      @(negedge clk);
      i_start = 1'b0;
      i_bin   = 16'd123;
      nvalid  = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (o_valid) begin
            nvalid++;
            check("busy_start_bcd", 32'(o_bcd), 32'h00042);
            check("busy_start_en", 32'(o_digit_en), 32'b00011);
         end else if (nvalid == 0) begin
            check("busy_start_hold", 32'(o_bcd), 32'(last_bcd));
         end
      end
      check("busy_start_count", 32'(nvalid), 32'd1);
      last_bcd = 20'h00042;
      last_en  = 5'b00011;

      // 5: reset mid-conversion discards the partial result
      @(negedge clk);
      i_bin   = 16'd9999;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_bcd", 32'(o_bcd), 32'h0);
      check("midrst_en", 32'(o_digit_en), 32'b00001);
      check("midrst_valid", 32'(o_valid), 32'd0);
      check("midrst_busy", 32'(o_busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (o_valid) nvalid++;
      end
      check("midrst_no_valid", 32'(nvalid), 32'd0);
      last_bcd = '0;
      last_en  = 5'b00001;
      convert(77);

      // 6: back-to-back stream with start held high, then randomised values
      vals = {7, 8, 9, 0, 65535, 10000, 9999, 1, 10, 99999 % 65536};
      while (vals.size() < 1000) vals.push_back(int'($urandom_range(0, 65535)));
      @(negedge clk);
      i_bin   = 16'(vals[0]);
      i_start = 1'b1;
      idx = 0;
      gap = 0;
      while (idx < vals.size()) begin
         @(negedge clk);
         gap++;
         if (gap > 30) begin
            check("stream_timeout", 32'(gap), 32'd18);
            break;
         end
         if (o_valid) begin
            check("stream_period", 32'(gap), 32'd18);
            check("stream_bcd", 32'(o_bcd), 32'(ref_bcd(vals[idx])));
            check("stream_en", 32'(o_digit_en), 32'(ref_mask(vals[idx])));
            check("stream_busy_gap", 32'(o_busy), 32'd0);
            idx++;
            gap = 0;
            if (idx < vals.size()) i_bin = 16'(vals[idx]);
            else i_start = 1'b0;
         end else begin
            check("stream_busy", 32'(o_busy), 32'd1);
            i_bin = 16'($urandom_range(0, 65535));
         end
      end
      i_start = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
